// File: rtl/mem_stage_pkg.sv
// Shared rv32 core package: op codes, stage bundles, memory-stage state
// and the store-lane helper functions used by mem_stage.
package core;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [3:0] {
    NONE    = 4'd0,
    INTEGER = 4'd1,
    BRANCH  = 4'd2,
    JUMP    = 4'd3,
    LOAD_B  = 4'd4,
    LOAD_H  = 4'd5,
    LOAD_W  = 4'd6,
    LOAD_BU = 4'd7,
    LOAD_HU = 4'd8,
    STORE_B = 4'd9,
    STORE_H = 4'd10,
    STORE_W = 4'd11
  } op_t;

  // Execute -> memory bundle: 4 + 3 + 32 + 32 + 5 = 76 bits
  typedef struct packed {
    op_t        op;
    logic [2:0] br;
    word_t      alu;
    word_t      rs2;
    reg_addr_t  rd;
  } mm_t;

  typedef struct packed {
    word_t     data;
    reg_addr_t addr;
  } rd_t;

  // Memory -> write-back bundle: 4 + 32 + 5 = 41 bits
  typedef struct packed {
    op_t op;
    rd_t rd;
  } wb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam word_t DATA_BASE = 32'h0000_1000;
  localparam word_t DATA_SIZE = 32'h0000_1000;
  localparam word_t MMIO_BASE = 32'h8000_0000;

  function automatic logic isload(input op_t op);
    return (op == LOAD_B) || (op == LOAD_H) || (op == LOAD_W) ||
           (op == LOAD_BU) || (op == LOAD_HU);
  endfunction

  function automatic logic isstore(input op_t op);
    return (op == STORE_B) || (op == STORE_H) || (op == STORE_W);
  endfunction

  // Byte lanes touched by a store at the given byte offset
  function automatic strb_t strobe(input op_t op, input logic [1:0] off);
    strb_t s;
    case (op)
      STORE_W: s = 4'b1111;
      STORE_H: s = 4'b0011 << off;
      STORE_B: s = 4'b0001 << off;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data replicated across lanes so the strobe alone selects bytes
  function automatic word_t store_data(input op_t op, input word_t rs2);
    word_t d;
    case (op)
      STORE_W: d = rs2;
      STORE_H: d = {2{rs2[15:0]}};
      STORE_B: d = {4{rs2[7:0]}};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Halves must sit on even offsets, words on offset 0
  function automatic logic misaligned(input op_t op, input logic [1:0] off);
    logic m;
    case (op)
      LOAD_H, LOAD_HU, STORE_H: m = off[0];
      LOAD_W, STORE_W:          m = (off != 2'b00);
      default:                  m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic in_range(input word_t a);
    return ((a >= DATA_BASE) && (a < (DATA_BASE + DATA_SIZE))) || (a >= MMIO_BASE);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of the response word
// and sign- or zero-extends it to 32 bits.
module load_align
  import core::*;
(
  input  op_t        i_op,
  input  logic [1:0] i_off,
  input  word_t      i_word,
  output word_t      o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension by load type
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = 32'h0000_0000;
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_off[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
    case (i_op)
      LOAD_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LOAD_BU: o_data = {24'h00_0000, w_byte};
      LOAD_H:  o_data = {{16{w_half[15]}}, w_half};
      LOAD_HU: o_data = {16'h0000, w_half};
      LOAD_W:  o_data = i_word;
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rv32 memory-access stage between execute and write-back.
// Optional build macro MEM_MISALIGN_TRAP_EN: when defined, misaligned
// halves/words take the fault path; otherwise the offset is rounded down.
module mem_stage
  import core::*;
#(
  parameter bit ADDR_LSB_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mm_valid,
  output logic        mm_ready,
  input  mm_t         mm,
  output logic        wb_valid,
  output wb_t         wb,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output strb_t       dmem_strb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        fault
);

  mem_state_t r_state, w_state_nxt;
  logic       r_wb_valid, w_wb_valid_nxt;
  wb_t        r_wb, w_wb_nxt;
  logic       r_fault, w_fault_nxt;
  logic       r_req_valid, w_req_valid_nxt;
  logic       r_we, w_we_nxt;
  word_t      r_addr, w_addr_nxt;
  word_t      r_wdata, w_wdata_nxt;
  strb_t      r_strb, w_strb_nxt;
  op_t        r_op, w_op_nxt;
  logic [1:0] r_off, w_off_nxt;
  reg_addr_t  r_rd, w_rd_nxt;

  logic       w_is_mem;
  logic       w_misalign;
  logic       w_bad;
  logic [1:0] w_off_eff;
  word_t      w_load_data;
  logic       w_unused;

  assign w_unused = ^{1'b0, mm.br};
  assign w_is_mem = isload(mm.op) || isstore(mm.op);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_is_mem && misaligned(mm.op, mm.alu[1:0]);
  assign w_off_eff  = mm.alu[1:0];
`else
  assign w_misalign = 1'b0;
  // Misaligned halves/words silently round down to their natural boundary
  always_comb begin
    case (mm.op)
      LOAD_H, LOAD_HU, STORE_H: w_off_eff = {mm.alu[1], 1'b0};
      LOAD_W, STORE_W:          w_off_eff = 2'b00;
      default:                  w_off_eff = mm.alu[1:0];
    endcase
  end
`endif

  assign w_bad = w_misalign || (ADDR_LSB_CHECK && !in_range(mm.alu));

  load_align u_load_align (
    .i_op   (r_op),
    .i_off  (r_off),
    .i_word (dmem_rsp_data),
    .o_data (w_load_data)
  );

  // Next-state and next-output logic for the IDLE/REQ/RESP sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_wb_valid_nxt  = 1'b0;
    w_wb_nxt        = r_wb;
    w_fault_nxt     = 1'b0;
    w_req_valid_nxt = r_req_valid;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_strb_nxt      = r_strb;
    w_op_nxt        = r_op;
    w_off_nxt       = r_off;
    w_rd_nxt        = r_rd;
    case (r_state)
      IDLE: begin
        if (mm_valid) begin
          if (!w_is_mem) begin
            w_wb_valid_nxt   = 1'b1;
            w_wb_nxt.op      = mm.op;
            w_wb_nxt.rd.data = mm.alu;
            w_wb_nxt.rd.addr = mm.rd;
          end else if (w_bad) begin
            w_fault_nxt      = 1'b1;
            w_wb_valid_nxt   = 1'b1;
            w_wb_nxt.op      = NONE;
            w_wb_nxt.rd.data = 32'h0000_0000;
            w_wb_nxt.rd.addr = 5'd0;
          end else begin
            w_req_valid_nxt = 1'b1;
            w_we_nxt        = isstore(mm.op);
            w_addr_nxt      = {mm.alu[31:2], 2'b00};
            w_wdata_nxt     = store_data(mm.op, mm.rs2);
            w_strb_nxt      = strobe(mm.op, w_off_eff);
            w_op_nxt        = mm.op;
            w_off_nxt       = w_off_eff;
            w_rd_nxt        = mm.rd;
            w_state_nxt     = REQ;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          w_req_valid_nxt = 1'b0;
          if (r_we) begin
            w_wb_valid_nxt   = 1'b1;
            w_wb_nxt.op      = r_op;
            w_wb_nxt.rd.data = 32'h0000_0000;
            w_wb_nxt.rd.addr = 5'd0;
            w_state_nxt      = IDLE;
          end else begin
            w_state_nxt = RESP;
          end
        end else begin
          w_state_nxt = REQ;
        end
      end
      RESP: begin
        if (dmem_rsp_valid) begin
          w_wb_valid_nxt   = 1'b1;
          w_wb_nxt.op      = r_op;
          w_wb_nxt.rd.data = w_load_data;
          w_wb_nxt.rd.addr = r_rd;
          w_state_nxt      = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_req_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_wb_valid  <= 1'b0;
      r_wb        <= '0;
      r_fault     <= 1'b0;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_strb      <= 4'b0000;
      r_op        <= NONE;
      r_off       <= 2'b00;
      r_rd        <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb        <= w_wb_nxt;
      r_fault     <= w_fault_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_strb      <= w_strb_nxt;
      r_op        <= w_op_nxt;
      r_off       <= w_off_nxt;
      r_rd        <= w_rd_nxt;
    end
  end

  assign mm_ready       = (r_state == IDLE);
  assign wb_valid       = r_wb_valid;
  assign wb             = r_wb;
  assign fault          = r_fault;
  assign dmem_req_valid = r_req_valid;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign dmem_strb      = r_strb;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, random
// transactions against an arithmetic reference model, and hand-written
// sequences for back-to-back pass-through and reset during a load.
module tb_mem_stage;
  import core::*;

  localparam logic [31:0] TB_DATA_BASE = 32'h0000_1000;
  localparam logic [31:0] TB_DATA_SIZE = 32'h0000_1000;
  localparam logic [31:0] TB_MMIO_BASE = 32'h8000_0000;

  logic        clk;
  logic        resetn;
  logic        mm_valid;
  logic        mm_ready;
  mm_t         mm_in;
  logic        wb_valid;
  wb_t         wb;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  strb_t       dmem_strb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          flt;
    op_t         wop;
    logic [31:0] wd;
    logic [4:0]  wa;
  } exp_t;

  typedef struct {
    string       name;
    op_t         op;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] rsp;
    int          dly;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];

  mem_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .mm_valid       (mm_valid),
    .mm_ready       (mm_ready),
    .mm             (mm_in),
    .wb_valid       (wb_valid),
    .wb             (wb),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_strb      (dmem_strb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " mm_ready"}, 32'(mm_ready), 32'd1);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, " wb_op"}, 32'(wb.op), 32'd0);
    chk({tag, " wb_data"}, wb.rd.data, 32'd0);
    chk({tag, " wb_addr"}, 32'(wb.rd.addr), 32'd0);
    chk({tag, " req_valid"}, 32'(dmem_req_valid), 32'd0);
    chk({tag, " we"}, 32'(dmem_we), 32'd0);
    chk({tag, " addr"}, dmem_addr, 32'd0);
    chk({tag, " wdata"}, dmem_wdata, 32'd0);
    chk({tag, " strb"}, 32'(dmem_strb), 32'd0);
    chk({tag, " fault"}, 32'(fault), 32'd0);
  endtask

  // Reference model: byte-level arithmetic straight from the stage rules
  function automatic exp_t model(input op_t op, input logic [31:0] alu, input logic [31:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] rsp);
    exp_t   e;
    int     size;
    int     off;
    bit     ld;
    bit     st;
    bit     bad;
    longint v;
    e.req = 1'b0; e.we = 1'b0; e.addr = 32'd0; e.strb = 4'd0; e.wdata = 32'd0;
    e.flt = 1'b0; e.wop = NONE; e.wd = 32'd0; e.wa = 5'd0;
    ld = op inside {LOAD_B, LOAD_H, LOAD_W, LOAD_BU, LOAD_HU};
    st = op inside {STORE_B, STORE_H, STORE_W};
    if (!ld && !st) begin
      e.wop = op; e.wd = alu; e.wa = rd;
      return e;
    end
    size = (op inside {LOAD_B, LOAD_BU, STORE_B}) ? 1 :
           (op inside {LOAD_H, LOAD_HU, STORE_H}) ? 2 : 4;
    off = int'(alu % 32'd4);
    bad = !(((alu >= TB_DATA_BASE) && (alu < TB_DATA_BASE + TB_DATA_SIZE)) || (alu >= TB_MMIO_BASE));
`ifdef MEM_MISALIGN_TRAP_EN
    bad = bad || ((off % size) != 0);
`else
    off = off - (off % size);
`endif
    if (bad) begin
      e.flt = 1'b1;
      return e;
    end
    e.req  = 1'b1;
    e.we   = st;
    e.addr = alu - (alu % 32'd4);
    e.strb = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(rs2 >> (8 * (i % size)));
    if (st) begin
      e.wop = op;
      return e;
    end
    v = longint'(rsp >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if ((op inside {LOAD_B, LOAD_H}) && (v >= (longint'(1) << (8 * size - 1))))
      v = v - (longint'(1) << (8 * size));
    e.wop = op;
    e.wd  = 32'(v);
    e.wa  = rd;
    return e;
  endfunction

  function automatic void add_vec(input string name, input op_t op, input logic [31:0] alu,
      input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rsp, input int dly,
      input bit req, input bit we, input logic [31:0] addr, input logic [3:0] strb,
      input logic [31:0] wdata, input bit flt, input op_t wop, input logic [31:0] wd,
      input logic [4:0] wa);
    vec_t v;
    v.name = name; v.op = op; v.alu = alu; v.rs2 = rs2; v.rd = rd; v.rsp = rsp; v.dly = dly;
    v.e.req = req; v.e.we = we; v.e.addr = addr; v.e.strb = strb; v.e.wdata = wdata;
    v.e.flt = flt; v.e.wop = wop; v.e.wd = wd; v.e.wa = wa;
    vecs.push_back(v);
  endfunction

  // One complete transaction: accept, bus handshake(s), write-back pulse
  task automatic run_txn(input string name, input op_t op, input logic [31:0] alu,
      input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rsp,
      input int req_dly, input int rsp_dly, input exp_t e);
    @(negedge clk);
    chk({name, " ready_idle"}, 32'(mm_ready), 32'd1);
    mm_valid    = 1'b1;
    mm_in.op    = op;
    mm_in.br    = 3'($urandom);
    mm_in.alu   = alu;
    mm_in.rs2   = rs2;
    mm_in.rd    = rd;
    @(negedge clk);
    mm_valid = 1'b0;
    if (e.req) begin
      for (int c = 0; c <= req_dly; c++) begin
        chk({name, " req_valid"}, 32'(dmem_req_valid), 32'd1);
        chk({name, " addr"}, dmem_addr, e.addr);
        chk({name, " we"}, 32'(dmem_we), 32'(e.we));
        if (e.we) begin
          chk({name, " strb"}, 32'(dmem_strb), 32'(e.strb));
          chk({name, " wdata"}, dmem_wdata, e.wdata);
        end
        chk({name, " ready_busy"}, 32'(mm_ready), 32'd0);
        chk({name, " wb_quiet"}, 32'(wb_valid), 32'd0);
        chk({name, " no_fault"}, 32'(fault), 32'd0);
        if (c == req_dly) begin
          dmem_req_ready = 1'b1;
          if (!e.we) begin
            dmem_rsp_valid = 1'b1;
            dmem_rsp_data  = ~rsp;
          end
        end
        @(negedge clk);
      end
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      chk({name, " req_drop"}, 32'(dmem_req_valid), 32'd0);
      if (!e.we) begin
        for (int c = 0; c < rsp_dly; c++) begin
          chk({name, " resp_wait_wb"}, 32'(wb_valid), 32'd0);
          chk({name, " resp_wait_ready"}, 32'(mm_ready), 32'd0);
          @(negedge clk);
        end
        chk({name, " early_rsp_ignored"}, 32'(wb_valid), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = rsp;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
      end
    end else begin
      chk({name, " no_req"}, 32'(dmem_req_valid), 32'd0);
    end
    chk({name, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({name, " wb_op"}, 32'(wb.op), 32'(e.wop));
    chk({name, " wb_data"}, wb.rd.data, e.wd);
    chk({name, " wb_addr"}, 32'(wb.rd.addr), 32'(e.wa));
    chk({name, " fault"}, 32'(fault), 32'(e.flt));
    chk({name, " ready_done"}, 32'(mm_ready), 32'd1);
    @(negedge clk);
    chk({name, " wb_pulse"}, 32'(wb_valid), 32'd0);
    chk({name, " fault_pulse"}, 32'(fault), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t         ops[12];
    op_t         op;
    logic [31:0] alu;
    logic [31:0] rsp;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          region;
    exp_t        e;

    ops = '{NONE, INTEGER, BRANCH, JUMP, LOAD_B, LOAD_H, LOAD_W, LOAD_BU, LOAD_HU,
            STORE_B, STORE_H, STORE_W};
    resetn         = 1'b0;
    mm_valid       = 1'b0;
    mm_in          = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_data  = 32'd0;

    //       name        op       alu           rs2           rd     rsp           dly req we addr          strb     wdata         flt wop      wd            wa
    add_vec("sb_lane3",  STORE_B, 32'h0000_1003, 32'h0000_00AB, 5'd9,  32'd0,        3, 1, 1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 0, STORE_B, 32'd0,        5'd0);
    add_vec("lh_sext",   LOAD_H,  32'h0000_1002, 32'd0,         5'd7,  32'h8001_0000, 1, 1, 0, 32'h0000_1000, 4'b0000, 32'd0,        0, LOAD_H,  32'hFFFF_8001, 5'd7);
    add_vec("lhu_zext",  LOAD_HU, 32'h0000_1002, 32'd0,         5'd7,  32'h8001_0000, 1, 1, 0, 32'h0000_1000, 4'b0000, 32'd0,        0, LOAD_HU, 32'h0000_8001, 5'd7);
    add_vec("lw_range",  LOAD_W,  32'h0000_2000, 32'd0,         5'd3,  32'd0,        0, 0, 0, 32'd0,        4'b0000, 32'd0,        1, NONE,    32'd0,        5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    add_vec("lw_mis",    LOAD_W,  32'h0000_1001, 32'd0,         5'd4,  32'hDEAD_BEEF, 0, 0, 0, 32'd0,        4'b0000, 32'd0,        1, NONE,    32'd0,        5'd0);
    add_vec("sh_mis",    STORE_H, 32'h0000_1003, 32'h0000_BEEF, 5'd3,  32'd0,        1, 0, 0, 32'd0,        4'b0000, 32'd0,        1, NONE,    32'd0,        5'd0);
`else
    add_vec("lw_mis",    LOAD_W,  32'h0000_1001, 32'd0,         5'd4,  32'hDEAD_BEEF, 0, 1, 0, 32'h0000_1000, 4'b0000, 32'd0,        0, LOAD_W,  32'hDEAD_BEEF, 5'd4);
    add_vec("sh_mis",    STORE_H, 32'h0000_1003, 32'h0000_BEEF, 5'd3,  32'd0,        1, 1, 1, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 0, STORE_H, 32'd0,        5'd0);
`endif
    add_vec("sh_hi",     STORE_H, 32'h0000_1006, 32'h1234_5678, 5'd2,  32'd0,        2, 1, 1, 32'h0000_1004, 4'b1100, 32'h5678_5678, 0, STORE_H, 32'd0,        5'd0);
    add_vec("sw_top",    STORE_W, 32'h0000_1FFC, 32'hCAFE_F00D, 5'd1,  32'd0,        0, 1, 1, 32'h0000_1FFC, 4'b1111, 32'hCAFE_F00D, 0, STORE_W, 32'd0,        5'd0);
    add_vec("lb_mmio",   LOAD_B,  32'h8000_0001, 32'd0,         5'd30, 32'h0000_8000, 2, 1, 0, 32'h8000_0000, 4'b0000, 32'd0,        0, LOAD_B,  32'hFFFF_FF80, 5'd30);
    add_vec("lbu_off1",  LOAD_BU, 32'h0000_1FFD, 32'd0,         5'd12, 32'h1234_5678, 0, 1, 0, 32'h0000_1FFC, 4'b0000, 32'd0,        0, LOAD_BU, 32'h0000_0056, 5'd12);
    add_vec("sb_below",  STORE_B, 32'h0000_0FFF, 32'h0000_0011, 5'd8,  32'd0,        0, 0, 0, 32'd0,        4'b0000, 32'd0,        1, NONE,    32'd0,        5'd0);
    add_vec("jump",      JUMP,    32'h0000_0044, 32'h0000_0099, 5'd1,  32'd0,        0, 0, 0, 32'd0,        4'b0000, 32'd0,        0, JUMP,    32'h0000_0044, 5'd1);
    add_vec("lw_mmio",   LOAD_W,  32'hFFFF_FFFC, 32'd0,         5'd31, 32'h0BAD_F00D, 3, 1, 0, 32'hFFFF_FFFC, 4'b0000, 32'd0,        0, LOAD_W,  32'h0BAD_F00D, 5'd31);

    // Reset state
    #12;
    chk_reset("por");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset("post_por");

    // Back-to-back pass-through: one write-back per cycle
    mm_valid  = 1'b1;
    mm_in.op  = INTEGER;
    mm_in.br  = 3'd0;
    mm_in.alu = 32'h0000_1234;
    mm_in.rs2 = 32'd0;
    mm_in.rd  = 5'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d wb_valid", k), 32'(wb_valid), 32'd1);
      chk($sformatf("b2b%0d wb_data", k), wb.rd.data, 32'h0000_1234);
      chk($sformatf("b2b%0d wb_addr", k), 32'(wb.rd.addr), 32'd5);
      chk($sformatf("b2b%0d wb_op", k), 32'(wb.op), 32'(INTEGER));
      chk($sformatf("b2b%0d ready", k), 32'(mm_ready), 32'd1);
      if (k == 2) mm_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b end wb_valid", 32'(wb_valid), 32'd0);

    // Directed table
    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].op, vecs[i].alu, vecs[i].rs2, vecs[i].rd, vecs[i].rsp,
              vecs[i].dly, vecs[i].dly, vecs[i].e);

    // Reset while waiting for a load response, then a stale response
    @(negedge clk);
    mm_valid  = 1'b1;
    mm_in.op  = LOAD_W;
    mm_in.alu = 32'h0000_1000;
    mm_in.rd  = 5'd6;
    @(negedge clk);
    mm_valid       = 1'b0;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rst_resp in_resp", 32'(mm_ready), 32'd0);
    resetn = 1'b0;
    #1;
    chk_reset("rst_resp");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h5555_5555;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("stale_rsp wb_valid", 32'(wb_valid), 32'd0);
    chk("stale_rsp ready", 32'(mm_ready), 32'd1);
    @(negedge clk);
    chk("stale_rsp wb_valid2", 32'(wb_valid), 32'd0);
    chk("stale_rsp req", 32'(dmem_req_valid), 32'd0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 150; n++) begin
      op     = ops[$urandom_range(0, 11)];
      region = int'($urandom_range(0, 3));
      case (region)
        0, 1:    alu = TB_DATA_BASE + 32'($urandom_range(0, 4095));
        2:       alu = TB_MMIO_BASE | ($urandom & 32'h7FFF_FFFF);
        default: alu = $urandom & 32'h7FFF_FFFF;
      endcase
      rs2 = $urandom;
      rd  = 5'($urandom);
      rsp = $urandom;
      e   = model(op, alu, rs2, rd, rsp);
      run_txn($sformatf("rnd%0d", n), op, alu, rs2, rd, rsp,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
